// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit bundle: redirect, instruction memory and decode handshakes
//
// Groups every non-clock/reset signal of ifu_fetch.
//   redirect_i/redirect_pc_i           : flush request and new fetch PC from execute
//   imem_req_o/imem_addr_o/imem_gnt_i  : request channel to instruction memory
//   imem_rvalid_i/imem_rdata_i         : in-order response channel from instruction memory
//   if_valid_o/if_pc_o/if_instr_o      : {pc, instr} presented to decode
//   id_ready_i                         : decode accepts the presented instruction
// Modport master is the fetch unit; modport slave is its surroundings.
interface ifu_fetch_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   redirect_i;
  logic [PC_WIDTH-1:0]    redirect_pc_i;
  logic                   imem_req_o;
  logic [PC_WIDTH-1:0]    imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [INSTR_WIDTH-1:0] imem_rdata_i;
  logic                   if_valid_o;
  logic [PC_WIDTH-1:0]    if_pc_o;
  logic [INSTR_WIDTH-1:0] if_instr_o;
  logic                   id_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit with credit-checked request issue and a small {pc, instr} buffer
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ifu_fetch_if.master (redirect, imem request/response, decode handshake)
// Optional feature: define IFU_BYPASS_EN to let a kept response go straight to decode
// when the buffer is empty and decode is ready (zero-cycle fetch-to-decode latency).
module ifu_fetch #(
  parameter int                     PC_WIDTH    = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter int                     DEPTH       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  ifu_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];

  logic                   req_en, flushing;
  logic                   redir, rvalid, req, grant, keep, bypass, push, pop, fifo_valid;
  logic [CW:0]            credit_used;
  logic [PC_WIDTH-1:0]    redir_pc;
  logic                   unused_pc_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_pc_lsbs = ^bus.redirect_pc_i[1:0];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // FLUSH is held exactly while drop is non-zero, so it doubles as the discard qualifier.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_RUN;
      S_RUN:   if (redir && drop_d != '0) state_d = S_FLUSH;
      S_FLUSH: if (drop_d == '0)          state_d = S_RUN;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    req_en   = 1'b0;
    flushing = 1'b0;
    case (state_q)
      S_RUN:   req_en = 1'b1;
      S_FLUSH: begin
        req_en   = 1'b1;
        flushing = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  assign redir    = bus.redirect_i;
  assign redir_pc = {bus.redirect_pc_i[PC_WIDTH-1:2], 2'b00};
  assign rvalid   = bus.imem_rvalid_i;

  // Credits count buffered entries plus in-flight requests that will be kept;
  // responses still to be dropped do not need a slot.
  assign credit_used = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, drop_q};
  assign req         = req_en & ~redir & (credit_used < (CW+1)'(DEPTH));
  assign grant       = req & bus.imem_gnt_i;

  assign keep       = rvalid & ~redir & ~flushing;
  assign fifo_valid = (count_q != '0) & ~redir;
  assign pop        = fifo_valid & bus.id_ready_i;

`ifdef IFU_BYPASS_EN
  assign bypass         = keep & (count_q == '0) & bus.id_ready_i;
  assign bus.if_valid_o = fifo_valid | bypass;
  assign bus.if_pc_o    = bypass ? resp_pc_q : pc_mem_q[rd_ptr_q];
  assign bus.if_instr_o = bypass ? bus.imem_rdata_i : instr_mem_q[rd_ptr_q];
`else
  assign bypass         = 1'b0;
  assign bus.if_valid_o = fifo_valid;
  assign bus.if_pc_o    = pc_mem_q[rd_ptr_q];
  assign bus.if_instr_o = instr_mem_q[rd_ptr_q];
`endif

  assign push            = keep & ~bypass;
  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = fetch_pc_q;

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    outst_d    = outst_q + CW'(grant) - CW'(rvalid);
    drop_d     = (flushing && rvalid) ? drop_q - 1'b1 : drop_q;
    fetch_pc_d = grant ? fetch_pc_q + PC_WIDTH'(4) : fetch_pc_q;
    resp_pc_d  = keep  ? resp_pc_q + PC_WIDTH'(4)  : resp_pc_q;
    if (redir) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Every request still in flight after this edge belongs to the old stream;
      // a response arriving now is already discarded, so it is not counted again.
      drop_d     = outst_q - CW'(rvalid);
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= resp_pc_q;
        instr_mem_q[wr_ptr_q] <= bus.imem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized scoreboard bench for ifu_fetch against a program-order stream model
module tb_ifu_fetch;
  localparam int          PCW      = 32;
  localparam int          IW       = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) bus ();

  ifu_fetch #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: decode must see the current stream in program order, and the
  // memory must be asked for the same stream in order.
  logic [31:0] exp_q[$];
  logic [31:0] next_pc, exp_req;
  int          xfers = 0;

  function automatic void refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_pc);
      next_pc += 32'd4;
    end
  endfunction

  function automatic void model_redirect(input logic [31:0] tgt);
    exp_q.delete();
    next_pc = {tgt[31:2], 2'b00};
    exp_req = next_pc;
    refill();
  endfunction

  // Instruction memory model: in-order, bounded outstanding, programmable latency.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          gnt_pct = 100, rdy_pct = 100, lat_min = 0, lat_max = 0;
  bit          mon_en = 1'b0;

  task automatic cycle(input bit redir, input logic [31:0] tgt);
    int  sz;
    bit  g;
    logic [31:0] a;
    sz = pend_addr.size();
    if (sz > 0 && pend_due[0] <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = word_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
    end
    bus.imem_gnt_i    = (sz < 3) && ($urandom_range(99) < gnt_pct);
    bus.id_ready_i    = ($urandom_range(99) < rdy_pct);
    bus.redirect_i    = redir;
    bus.redirect_pc_i = redir ? tgt : $urandom;
    if (redir) model_redirect(tgt);
    @(negedge clk);
    g = bus.imem_req_o & bus.imem_gnt_i;
    a = bus.imem_addr_o;
    @(posedge clk);
    #1;
    cyc++;
    if (g) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
    end
  endtask

  task automatic wait_xfer(input int n, input int budget, input string name);
    int s, k;
    s = xfers;
    k = 0;
    while (xfers < s + n && k < budget) begin
      cycle(1'b0, 32'h0);
      k++;
    end
    check(xfers >= s + n, name, xfers - s, n);
  endtask

  // Monitor: compares every presented transfer and every granted address with the model.
  bit          hold_q = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.redirect_i) begin
        check(!bus.if_valid_o, "valid_in_redirect", bus.if_valid_o, 0);
        check(!bus.imem_req_o, "req_in_redirect", bus.imem_req_o, 0);
      end else if (hold_q) begin
        check(bus.if_valid_o && bus.if_pc_o == hold_pc && bus.if_instr_o == hold_instr,
              "hold_stable", bus.if_pc_o, hold_pc);
      end
      if (bus.imem_req_o)
        check(bus.imem_addr_o[1:0] == 2'b00, "addr_aligned", bus.imem_addr_o, {bus.imem_addr_o[31:2], 2'b00});
      if (bus.imem_req_o && bus.imem_gnt_i) begin
        check(bus.imem_addr_o == exp_req, "req_addr", bus.imem_addr_o, exp_req);
        exp_req += 32'd4;
      end
      if (bus.if_valid_o && bus.id_ready_i) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check(bus.if_pc_o == e, "if_pc", bus.if_pc_o, e);
        check(bus.if_instr_o == word_of(e), "if_instr", bus.if_instr_o, word_of(e));
        xfers++;
        refill();
      end
      hold_q     = bus.if_valid_o && !bus.id_ready_i;
      hold_pc    = bus.if_pc_o;
      hold_instr = bus.if_instr_o;
    end
  end

  initial begin
    logic [31:0] tgt;
    model_redirect(RESET_PC);
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.id_ready_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(bus.imem_req_o == 1'b0, "rst_req", bus.imem_req_o, 0);
    check(bus.imem_addr_o == RESET_PC, "rst_addr", bus.imem_addr_o, RESET_PC);
    check(bus.if_valid_o == 1'b0, "rst_valid", bus.if_valid_o, 0);
    check(bus.if_pc_o == 32'h0, "rst_pc", bus.if_pc_o, 0);
    check(bus.if_instr_o == 32'h0, "rst_instr", bus.if_instr_o, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check(bus.imem_req_o == 1'b1, "first_req", bus.imem_req_o, 1);
    check(bus.imem_addr_o == RESET_PC, "first_addr", bus.imem_addr_o, RESET_PC);

    // Always-grant, 1-cycle memory, decode always ready.
    begin
      int s;
      s = xfers;
      repeat (12) cycle(1'b0, 32'h0);
      check(xfers - s >= 4, "stream_progress", xfers - s, 4);
    end

    // Decode stalls: buffer fills, requests stop, head holds at 0x0.
    rdy_pct = 0;
    cycle(1'b1, 32'h0);
    repeat (6) cycle(1'b0, 32'h0);
    check(bus.imem_req_o == 1'b0, "full_req_off", bus.imem_req_o, 0);
    check(bus.if_valid_o == 1'b1, "full_valid", bus.if_valid_o, 1);
    check(bus.if_pc_o == 32'h0, "full_head_pc", bus.if_pc_o, 0);
    check(bus.if_instr_o == word_of(32'h0), "full_head_instr", bus.if_instr_o, word_of(32'h0));
    rdy_pct = 100;
    wait_xfer(3, 40, "drain_after_stall");

    // Redirect with requests in flight on a 2-cycle memory.
    lat_min = 2;
    lat_max = 2;
    repeat (6) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h100);
    wait_xfer(2, 60, "redirect_0x100");

    // Back-to-back redirects while flushing.
    lat_min = 1;
    lat_max = 3;
    repeat (4) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h200);
    cycle(1'b1, 32'h300);
    wait_xfer(3, 80, "redirect_0x300");

    // Unaligned target and PC wrap.
    lat_min = 0;
    lat_max = 0;
    cycle(1'b1, 32'h0000_0103);
    wait_xfer(2, 40, "redirect_0x103");
    cycle(1'b1, 32'hFFFF_FFFC);
    wait_xfer(3, 40, "wrap");

    // Randomized traffic.
    gnt_pct = 80;
    rdy_pct = 70;
    lat_max = 3;
    begin
      int s;
      s = xfers;
      repeat (1500) begin
        if ($urandom_range(99) < 3) begin
          case ($urandom_range(3))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            2:       tgt = 32'($urandom_range(4095));
            default: tgt = 32'h0000_0103;
          endcase
          cycle(1'b1, tgt);
        end else begin
          cycle(1'b0, 32'h0);
        end
      end
      check(xfers - s >= 100, "random_progress", xfers - s, 100);
    end

    gnt_pct = 100;
    rdy_pct = 100;
    lat_max = 0;
    wait_xfer(5, 100, "final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
